// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: bubble-sort sequencer over a 4-entry register file, one compare-swap per clock.
// Define SORT_STATS_EN to add the swap_cnt / cmp_cnt statistics outputs.
module sort_seq_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         desc,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic [W-1:0] s0,
  output logic [W-1:0] s1,
  output logic [W-1:0] s2,
  output logic [W-1:0] s3,
`ifdef SORT_STATS_EN
  output logic [2:0]   swap_cnt,
  output logic [2:0]   cmp_cnt,
`endif
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] r [4];
  logic [1:0]   p, i;
  logic         swapped, mode;
  logic [W-1:0] a, b;
  logic         do_swap, last, pass_swapped, finish;

`ifdef SORT_STATS_EN
  logic [2:0]   swap_acc, cmp_acc;
`endif

  // The pair under test and whether this compare ends the sort.
  always_comb begin
    a            = r[i];
    b            = r[i + 2'd1];
    do_swap      = mode ? (a < b) : (a > b);
    last         = (i == (2'd2 - p));
    pass_swapped = swapped | do_swap;
    finish       = last && ((p == 2'd2) || !pass_swapped);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CMP;
      CMP:     if (finish) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r[k] <= '0;
      p       <= '0;
      i       <= '0;
      swapped <= 1'b0;
      mode    <= 1'b0;
      s0      <= '0;
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r[0]    <= x0;
            r[1]    <= x1;
            r[2]    <= x2;
            r[3]    <= x3;
            mode    <= desc;
            p       <= '0;
            i       <= '0;
            swapped <= 1'b0;
          end
        end
        CMP: begin
          if (do_swap) begin
            r[i]        <= b;
            r[i + 2'd1] <= a;
          end
          // Advance within the pass, or open a new pass unless the sort is finished.
          if (!last) begin
            i       <= i + 2'd1;
            swapped <= pass_swapped;
          end else if (!finish) begin
            p       <= p + 2'd1;
            i       <= '0;
            swapped <= 1'b0;
          end
        end
        FIN: begin
          s0   <= r[0];
          s1   <= r[1];
          s2   <= r[2];
          s3   <= r[3];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_STATS_EN
  // Counters run during the sort and are published together with the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_acc <= '0;
      cmp_acc  <= '0;
      swap_cnt <= '0;
      cmp_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            swap_acc <= '0;
            cmp_acc  <= '0;
          end
        end
        CMP: begin
          cmp_acc  <= cmp_acc + 3'd1;
          swap_acc <= swap_acc + {2'b00, do_swap};
        end
        FIN: begin
          swap_cnt <= swap_acc;
          cmp_cnt  <= cmp_acc;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed self-checking bench for sort_seq_ctrl; stats outputs are checked when SORT_STATS_EN is defined.
module tb_sort_seq_ctrl;
  localparam int W = 4;

  logic         clk, rst, start, desc, busy, done;
  logic [W-1:0] x0, x1, x2, x3, s0, s1, s2, s3;
`ifdef SORT_STATS_EN
  logic [2:0]   swap_cnt, cmp_cnt;
`endif
  int checks = 0;
  int errors = 0;

  sort_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .desc(desc),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
`ifdef SORT_STATS_EN
    .swap_cnt(swap_cnt), .cmp_cnt(cmp_cnt),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] e0, e1, e2, e3);
    checkOutput({tag, " s0"}, s0, e0);
    checkOutput({tag, " s1"}, s1, e1);
    checkOutput({tag, " s2"}, s2, e2);
    checkOutput({tag, " s3"}, s3, e3);
  endtask

  // Called at a negedge; the following posedge is the accepting edge E0.
  task automatic applyStimulus(input logic [W-1:0] a, b, c, d, input logic dsc);
    x0 = a; x1 = b; x2 = c; x3 = d; desc = dsc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("accept busy", busy, 1);
    checkOutput("accept done", done, 0);
  endtask

  // Waits (bounded) for done, counting edges after E0; optionally injects a start while busy.
  task automatic waitDone(input string tag, input int lat, input logic [W-1:0] e0, e1, e2, e3,
                          input logic [2:0] esw, input logic [2:0] ecmp, input int intr);
    int k = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (intr > 0 && n == intr) begin
        x0 = 9; x1 = 9; x2 = 9; x3 = 9; desc = ~desc; start = 1'b1;
      end else if (intr > 0 && n == intr + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        k = n;
        break;
      end
      checkOutput({tag, " busy"}, busy, 1);
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, k, lat);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " busy at done"}, busy, 0);
    checkResult(tag, e0, e1, e2, e3);
`ifdef SORT_STATS_EN
    checkOutput({tag, " swap_cnt"}, swap_cnt, esw);
    checkOutput({tag, " cmp_cnt"}, cmp_cnt, ecmp);
`else
    if (esw > 3'd6 || ecmp > 3'd6) $display("[TB] unexpected stats table entry");
`endif
  endtask

  task automatic checkPulseEnd(input string tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, done, 0);
    checkOutput({tag, " idle"}, busy, 0);
  endtask

  initial begin
    clk = 0; rst = 0; start = 0; desc = 0;
    x0 = 0; x1 = 0; x2 = 0; x3 = 0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    checkResult("reset", 0, 0, 0, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResult("reset hold", 0, 0, 0, 0);
    checkOutput("reset hold busy", busy, 0);
    checkOutput("reset hold done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(3, 1, 2, 0, 0);
    waitDone("asc", 7, 0, 1, 2, 3, 5, 6, 0);
    checkPulseEnd("asc");

    applyStimulus(3, 1, 2, 0, 1);
    waitDone("desc", 6, 3, 2, 1, 0, 1, 5, 0);
    checkPulseEnd("desc");

    applyStimulus(1, 2, 3, 4, 0);
    waitDone("sorted", 4, 1, 2, 3, 4, 0, 3, 0);
    checkPulseEnd("sorted");

    applyStimulus(4, 3, 2, 1, 0);
    waitDone("reverse", 7, 1, 2, 3, 4, 6, 6, 0);
    checkPulseEnd("reverse");

    // Start with 9,9,9,9 two cycles into the sort must be ignored.
    applyStimulus(3, 1, 2, 0, 0);
    waitDone("ignore", 7, 0, 1, 2, 3, 5, 6, 2);
    checkPulseEnd("ignore");

    // Start raised in the done cycle is accepted immediately.
    applyStimulus(1, 2, 3, 4, 0);
    waitDone("first", 4, 1, 2, 3, 4, 0, 3, 0);
    applyStimulus(2, 2, 1, 1, 0);
    waitDone("equal", 7, 1, 1, 2, 2, 4, 6, 0);
    checkPulseEnd("equal");

    // Reset after three compares of a reverse-sorted vector.
    applyStimulus(4, 3, 2, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResult("midrst", 0, 0, 0, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst done", done, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst held busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(5, 0, 5, 0, 0);
    waitDone("after rst", 7, 0, 0, 5, 5, 3, 6, 0);
    checkPulseEnd("after rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_seq_ctrl.md
Name: sort_seq_ctrl

Overview:
- Sequencing controller for the 4-entry sort datapath.
- Accepts a start request and captures four operands into an internal register file.
- Drives one shared compare-and-swap unit, one compare per clock, as a bubble sort with early exit on a swap-free pass.
- Publishes the sorted vector with a one-cycle done pulse; sits between the operand switches/host logic and the display/LED outputs.

Parameters:
- W, 4, data width of each entry in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  sort request; sampled only in IDLE.
- desc  in  1  order select, captured with start: 0 = ascending (s0 smallest), 1 = descending (s0 largest).
- x0..x3  in  W each  operands, captured on the accepting edge.
- s0..s3  out  W each  sorted result, registered, held until the next completion.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state, including mid-sort):
  - state = IDLE; internal r0..r3, pass p, index i, swapped flag, mode all cleared.
  - s0..s3 = 0, busy = 0, done = 0.
- States:
  - IDLE: on start=1 at edge E0: r[k] <= x[k], mode <= desc, p <= 0, i <= 0, swapped <= 0; go to CMP. Otherwise stay.
  - CMP: each edge does one compare-swap on (r[i], r[i+1]).
    - Swap condition: mode=0: r[i] > r[i+1]; mode=1: r[i] < r[i+1].
    - Equal values never swap (stable); any swap sets swapped.
    - Last index of pass p is i = 2-p.
    - If i < 2-p: i <= i+1.
    - Else, if p==2 or no swap occurred this pass (including the current compare): go to FIN.
    - Else: p <= p+1, i <= 0, swapped <= 0.
  - FIN: s[k] <= r[k], done <= 1 for exactly one cycle; go to IDLE.
- Compare count c ranges 3..6; p and i fit in 2 bits, with no wrap beyond p=2.
- Latency: done is high in the cycle after edge E(c+1), counting E0 as the accepting edge.
  - Already-sorted input: c=3, done 4 clocks after E0.
  - Reverse-sorted input: c=6, done 7 clocks after E0.
- busy is high from after E0 until the FIN edge; busy and done never overlap.
- start while busy is ignored and not queued; x and desc changes while busy have no effect.
- start high in the done cycle is accepted, since state is IDLE.
- s0..s3 change only at the FIN edge; no intermediate values are exposed.
- done is registered and deasserts on the edge after it rises.

Optional Feature:
- Macro SORT_STATS_EN.
- Defined:
  - Adds outputs swap_cnt [2:0] and cmp_cnt [2:0], registered at the FIN edge alongside s0..s3.
  - swap_cnt is the number of swaps performed (0..6); cmp_cnt is the number of compares (3..6).
  - Both reset to 0 and hold until the next completion.
  - Internal counters clear on the accepting edge.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with no clock -> s0..s3=0, busy=0, done=0 immediately; hold 3 clocks, no change.
- Ascending: x=3,1,2,0, desc=0, pulse start -> s=0,1,2,3; done a single pulse; busy high through the FIN cycle; swap_cnt=5, cmp_cnt=6 if SORT_STATS_EN.
- Descending, same operands: desc=1 -> s=3,2,1,0.
- Early exit and latency: x=1,2,3,4 asc -> done 4 clocks after E0, cmp_cnt=3, swap_cnt=0. x=4,3,2,1 asc -> done 7 clocks after E0, s=1,2,3,4, cmp_cnt=6.
- Busy/overlap:
  - Start again with x=9,9,9,9 two cycles into a sort -> ignored; first result unchanged.
  - Start held high during the done cycle -> new sort begins; busy rises next cycle.
  - Equal values x=2,2,1,1 asc -> s=1,1,2,2, swap_cnt=4.
- Reset mid-sort: rst asserted after 3 compares of x=4,3,2,1 -> outputs 0, IDLE. A following start with x=5,0,5,0 sorts cleanly to 0,0,5,5.
